hv_fold_distance_accum: RTL and testbench

//  Pipelined Hamming-distance engine for folded hypervectors: XORs one query fold against one

---
 rtl/hv_fold_distance_accum.sv | 128 ++++++++++++
 tb/tb_hv_fold_distance_accum.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hv_fold_distance_accum.sv
// Pipelined Hamming-distance accumulator for folded hypervectors: one fold pair per cycle is
// XOR-ed and popcounted, and NUM_FOLDS partial counts are summed into a single distance.
module hv_fold_distance_accum #(
    parameter int NUM_FOLDS       = 5,
    parameter int NUM_FOLDS_WIDTH = 3,
    parameter int FOLD_WIDTH      = 400,
    parameter int DISTANCE_WIDTH  = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fold_valid,
    output logic                       fold_ready,
    input  logic [FOLD_WIDTH-1:0]      query_fold,
    input  logic [FOLD_WIDTH-1:0]      class_fold,
    output logic [NUM_FOLDS_WIDTH-1:0] fold_idx,
    output logic                       dist_valid,
    input  logic                       dist_ready,
    output logic [DISTANCE_WIDTH-1:0]  distance
);

    localparam int PC_WIDTH    = $clog2(FOLD_WIDTH + 1);
    localparam int TREE_LEVELS = $clog2(FOLD_WIDTH);
    localparam int TREE_LEAVES = 1 << TREE_LEVELS;

    logic [FOLD_WIDTH-1:0]      diffBits;
    logic [PC_WIDTH-1:0]        treeSum;

    logic [NUM_FOLDS_WIDTH-1:0] foldIdx_q, foldIdx_d;
    logic [PC_WIDTH-1:0]        pc_q, pc_d;
    logic                       pcValid_q, pcValid_d;
    logic                       pcLast_q, pcLast_d;
    logic [DISTANCE_WIDTH-1:0]  acc_q, acc_d;
    logic [DISTANCE_WIDTH-1:0]  distance_q, distance_d;
    logic                       distValid_q, distValid_d;

    logic                       stall;
    logic                       accept;
    logic                       advance;
    logic                       lastSlot;
    logic [DISTANCE_WIDTH-1:0]  pcExt;

    assign diffBits = query_fold ^ class_fold;

    // Balanced popcount tree: leaves padded to a power of two, every node carries the full
    // PC_WIDTH so no partial sum can overflow.
    for (genvar l = 0; l <= TREE_LEVELS; l++) begin : g_level
        localparam int NODES = TREE_LEAVES >> l;
        logic [PC_WIDTH-1:0] levelSum [NODES];
        for (genvar k = 0; k < NODES; k++) begin : g_node
            if (l == 0) begin : g_leaf
                if (k < FOLD_WIDTH) begin : g_bit
                    assign levelSum[k] = PC_WIDTH'(diffBits[k]);
                end else begin : g_pad
                    assign levelSum[k] = '0;
                end
            end else begin : g_add
                assign levelSum[k] = g_level[l-1].levelSum[2*k] + g_level[l-1].levelSum[2*k+1];
            end
        end
    end

    assign treeSum = g_level[TREE_LEVELS].levelSum[0];

    always_comb begin
        stall    = pcValid_q && pcLast_q && distValid_q && !dist_ready;
        accept   = fold_valid && !stall;
        advance  = pcValid_q && !stall;
        lastSlot = (foldIdx_q == NUM_FOLDS_WIDTH'(NUM_FOLDS - 1));
        pcExt    = DISTANCE_WIDTH'(pc_q);

        foldIdx_d = foldIdx_q;
        if (accept) begin
            foldIdx_d = lastSlot ? '0 : foldIdx_q + NUM_FOLDS_WIDTH'(1);
        end

        pcValid_d = pcValid_q;
        pcLast_d  = pcLast_q;
        pc_d      = pc_q;
        if (!stall) begin
            pcValid_d = accept;
            pcLast_d  = accept && lastSlot;
            pc_d      = treeSum;
        end

        // A consumed result is dropped unless a fresh last fold overwrites it in the same cycle.
        acc_d       = acc_q;
        distance_d  = distance_q;
        distValid_d = distValid_q;
        if (distValid_q && dist_ready) begin
            distValid_d = 1'b0;
        end
        if (advance) begin
            if (pcLast_q) begin
                distance_d  = acc_q + pcExt;
                distValid_d = 1'b1;
                acc_d       = '0;
            end else begin
                acc_d = acc_q + pcExt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            foldIdx_q   <= '0;
            pc_q        <= '0;
            pcValid_q   <= 1'b0;
            pcLast_q    <= 1'b0;
            acc_q       <= '0;
            distance_q  <= '0;
            distValid_q <= 1'b0;
        end else begin
            foldIdx_q   <= foldIdx_d;
            pc_q        <= pc_d;
            pcValid_q   <= pcValid_d;
            pcLast_q    <= pcLast_d;
            acc_q       <= acc_d;
            distance_q  <= distance_d;
            distValid_q <= distValid_d;
        end
    end

    assign fold_ready = !stall;
    assign fold_idx   = foldIdx_q;
    assign dist_valid = distValid_q;
    assign distance   = distance_q;

endmodule

// File: tb/tb_hv_fold_distance_accum.sv
// Bench for hv_fold_distance_accum: directed folded vectors with hand-computed distances feed a
// scoreboard queue that an independent monitor drains on every output handshake.
module tb_hv_fold_distance_accum;

    localparam int NF  = 5;
    localparam int NFW = 3;
    localparam int FW  = 400;
    localparam int DW  = 11;

    logic           clk = 1'b0;
    logic           rst;
    logic           foldValid;
    logic           foldReady;
    logic [FW-1:0]  queryFold;
    logic [FW-1:0]  classFold;
    logic [NFW-1:0] foldIdx;
    logic           distValid;
    logic           distReady;
    logic [DW-1:0]  distance;

    int compared   = 0;
    int mismatched = 0;
    int cycleCount = 0;
    bit randReady  = 1'b0;
    int scoreboard [$];

    hv_fold_distance_accum #(
        .NUM_FOLDS(NF), .NUM_FOLDS_WIDTH(NFW), .FOLD_WIDTH(FW), .DISTANCE_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .fold_valid(foldValid), .fold_ready(foldReady),
        .query_fold(queryFold), .class_fold(classFold),
        .fold_idx(foldIdx),
        .dist_valid(distValid), .dist_ready(distReady), .distance(distance)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every output handshake consumes the oldest expected distance.
    always @(negedge clk) begin
        if (!rst && distValid && distReady) begin
            if (scoreboard.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_result: got %0d, expected no result", distance);
            end else begin
                checkOutput("distance", int'(distance), scoreboard.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (randReady) distReady = ($urandom_range(0, 3) != 0);
    endtask

    function automatic logic [FW-1:0] onesLow(input int n);
        logic [FW-1:0] f = '0;
        for (int i = 0; i < n; i++) f[i] = 1'b1;
        return f;
    endfunction

    function automatic logic [FW-1:0] randFold();
        logic [FW-1:0] f = '0;
        for (int i = 0; i < FW; i++) f[i] = 1'($urandom_range(0, 1));
        return f;
    endfunction

    // Present one fold and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic applyStimulus(input logic [FW-1:0] q, input logic [FW-1:0] c, input int expIdx);
        int waitCnt = 0;
        foldValid = 1'b1;
        queryFold = q;
        classFold = c;
        @(negedge clk);
        while (!foldReady && waitCnt < 200) begin
            tick();
            @(negedge clk);
            waitCnt++;
        end
        if (!foldReady) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL fold_accept_timeout: got fold_ready=0, expected 1");
            foldValid = 1'b0;
            return;
        end
        if (expIdx >= 0) checkOutput("fold_idx", int'(foldIdx), expIdx);
        tick();
        foldValid = 1'b0;
    endtask

    // Fold f differs from its query in exactly cnt[f] bits; expDist is the hand-summed total.
    task automatic sendVector(input int cnt [NF], input int expDist);
        logic [FW-1:0] q;
        scoreboard.push_back(expDist);
        for (int f = 0; f < NF; f++) begin
            q = randFold();
            applyStimulus(q, q ^ onesLow(cnt[f]), f);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (scoreboard.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        if (scoreboard.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: got %0d results pending, expected 0", scoreboard.size());
        end
    endtask

    initial begin
        int t0;
        int expSum;
        logic [FW-1:0] rq [NF];
        logic [FW-1:0] rc [NF];

        rst       = 1'b1;
        foldValid = 1'b0;
        queryFold = '0;
        classFold = '0;
        distReady = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_fold_idx", int'(foldIdx), 0);
        checkOutput("reset_dist_valid", int'(distValid), 0);
        checkOutput("reset_distance", int'(distance), 0);
        checkOutput("reset_fold_ready", int'(foldReady), 1);
        tick();

        // All-zero query against all-ones class: 5 x 400 differing bits.
        $display("[TB] test 1: all-zero vs all-ones");
        scoreboard.push_back(2000);
        for (int f = 0; f < NF; f++) applyStimulus('0, '1, f);
        @(negedge clk);
        checkOutput("latency_not_yet_valid", int'(distValid), 0);
        checkOutput("fold_idx_wrap", int'(foldIdx), 0);
        @(negedge clk);
        checkOutput("latency_valid", int'(distValid), 1);
        checkOutput("latency_distance", int'(distance), 2000);
        tick();
        drain();

        $display("[TB] test 2: identical folds, then one bit per fold");
        sendVector('{0, 0, 0, 0, 0}, 0);
        sendVector('{1, 1, 1, 1, 1}, 5);
        drain();

        $display("[TB] test 3: back-to-back vectors");
        t0 = cycleCount;
        sendVector('{3, 4, 5, 0, 5}, 17);
        sendVector('{400, 400, 400, 34, 0}, 1234);
        checkOutput("throughput_cycles", cycleCount - t0, 10);
        drain();

        // Result A waits unconsumed while vector B streams in and its last fold stalls.
        $display("[TB] test 4: backpressure");
        distReady = 1'b0;
        sendVector('{60, 60, 60, 60, 60}, 300);
        sendVector('{10, 20, 30, 7, 10}, 77);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_fold_ready", int'(foldReady), 0);
            checkOutput("stall_dist_valid", int'(distValid), 1);
            checkOutput("stall_distance_hold", int'(distance), 300);
        end
        tick();
        distReady = 1'b1;
        drain();

        $display("[TB] test 5: reset mid-vector");
        for (int f = 0; f < 3; f++) applyStimulus(randFold(), randFold(), f);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_fold_idx", int'(foldIdx), 0);
        checkOutput("midreset_dist_valid", int'(distValid), 0);
        tick();
        sendVector('{80, 80, 80, 80, 80}, 400);
        drain();

        $display("[TB] test 6: random folds with gaps and backpressure");
        randReady = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            expSum = 0;
            for (int f = 0; f < NF; f++) begin
                rq[f] = randFold();
                rc[f] = (v % 7 == 0) ? ~rq[f] : randFold();
                expSum += $countones(rq[f] ^ rc[f]);
            end
            scoreboard.push_back(expSum);
            for (int f = 0; f < NF; f++) begin
                applyStimulus(rq[f], rc[f], f);
                if ($urandom_range(0, 3) == 0) tick();
            end
        end
        randReady = 1'b0;
        distReady = 1'b1;
        drain();

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
